// File: rtl/cluster_resp_merge_pkg.sv
// cluster_resp_merge_pkg: shared constants for the cluster response merger
package cluster_resp_merge_pkg;
   localparam int unsigned MaxNrClusters   = 8;
   localparam int unsigned DefTransIdWidth = 5;
   localparam int unsigned FifoDepth       = 2;
endpackage

// File: rtl/cluster_resp_merge_fifo.sv
// cluster_resp_merge_fifo: two-entry registered (non fall-through) response buffer
module cluster_resp_merge_fifo
   import cluster_resp_merge_pkg::*;
#(
   parameter int unsigned DataWidth = 8
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 push_i,
   input  logic [DataWidth-1:0] data_i,
   input  logic                 pop_i,
   output logic [DataWidth-1:0] data_o,
   output logic                 full_o,
   output logic                 empty_o
);
   logic [FifoDepth-1:0][DataWidth-1:0] mem_q, mem_d;
   logic                                wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [1:0]                          cnt_q, cnt_d;
   logic                                push, pop;

   assign full_o  = cnt_q == 2'd2;
   assign empty_o = cnt_q == 2'd0;
   assign push    = push_i && !full_o;
   assign pop     = pop_i && !empty_o;
   assign data_o  = mem_q[rd_ptr_q];

   // Write slot, pointer and occupancy next-state
   always_comb begin
      mem_d = mem_q;
      if (push) mem_d[wr_ptr_q] = data_i;
      wr_ptr_d = wr_ptr_q ^ push;
      rd_ptr_d = rd_ptr_q ^ pop;
      cnt_d    = cnt_q + {1'b0, push} - {1'b0, pop};
   end

   // Storage and pointer registers, emptied by reset
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         mem_q    <= '0;
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         cnt_q    <= 2'd0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end
endmodule

// File: rtl/cluster_resp_merge.sv
// cluster_resp_merge: joins per-cluster scalar responses and completion status into one stream
module cluster_resp_merge
   import cluster_resp_merge_pkg::*;
#(
   parameter int unsigned NrClusters   = 4,
   parameter int unsigned ResultWidth  = 64,
   parameter int unsigned TransIdWidth = DefTransIdWidth,
   parameter int unsigned CplCntWidth  = 4
) (
   input  logic                                    clk_i,
   input  logic                                    rst_ni,
   input  logic [NrClusters-1:0]                   cl_resp_valid_i,
   output logic [NrClusters-1:0]                   cl_resp_ready_o,
   input  logic [NrClusters-1:0][ResultWidth-1:0]  cl_resp_result_i,
   input  logic [NrClusters-1:0][TransIdWidth-1:0] cl_resp_trans_id_i,
   input  logic [NrClusters-1:0]                   cl_resp_exception_i,
   input  logic [NrClusters-1:0]                   cl_store_pending_i,
   input  logic [NrClusters-1:0]                   cl_load_complete_i,
   input  logic [NrClusters-1:0]                   cl_store_complete_i,
   output logic                                    resp_valid_o,
   input  logic                                    resp_ready_i,
   output logic [ResultWidth-1:0]                  resp_result_o,
   output logic [TransIdWidth-1:0]                 resp_trans_id_o,
   output logic                                    resp_exception_o,
   output logic                                    store_pending_o,
   output logic                                    load_complete_o,
   output logic                                    store_complete_o,
   output logic                                    id_mismatch_o
);
   localparam int unsigned             EntryWidth = ResultWidth + TransIdWidth + 1;
   localparam logic [CplCntWidth-1:0] CntMax     = '1;
   localparam logic [CplCntWidth-1:0] CntOne     = CplCntWidth'(1);

   logic [NrClusters-1:0][EntryWidth-1:0]             fifo_wdata, fifo_rdata;
   logic [NrClusters-1:0]                             fifo_full, fifo_empty;
   logic                                              merge, mismatch, exc_any, unused_res;
   logic                                              resp_valid_q, resp_valid_d;
   logic [ResultWidth-1:0]                            resp_result_q, resp_result_d;
   logic [TransIdWidth-1:0]                           resp_trans_id_q, resp_trans_id_d;
   logic                                              resp_exception_q, resp_exception_d;
   logic                                              id_mismatch_q, id_mismatch_d;
   logic                                              store_pending_q, store_pending_d;
   logic [1:0][NrClusters-1:0]                        cpl;
   logic [1:0][NrClusters-1:0][CplCntWidth-1:0]       cnt_q, cnt_d;
   logic [1:0]                                        cpl_all, cpl_pulse_q, cpl_pulse_d;

   for (genvar c = 0; c < NrClusters; c++) begin : g_fifo
      assign fifo_wdata[c] = {cl_resp_exception_i[c], cl_resp_trans_id_i[c], cl_resp_result_i[c]};
      cluster_resp_merge_fifo #(.DataWidth(EntryWidth)) i_fifo (
         .clk_i   (clk_i),
         .rst_ni  (rst_ni),
         .push_i  (cl_resp_valid_i[c]),
         .data_i  (fifo_wdata[c]),
         .pop_i   (merge),
         .data_o  (fifo_rdata[c]),
         .full_o  (fifo_full[c]),
         .empty_o (fifo_empty[c])
      );
   end

   assign cl_resp_ready_o  = ~fifo_full;
   assign cpl              = {cl_store_complete_i, cl_load_complete_i};
   assign resp_valid_o     = resp_valid_q;
   assign resp_result_o    = resp_result_q;
   assign resp_trans_id_o  = resp_trans_id_q;
   assign resp_exception_o = resp_exception_q;
   assign id_mismatch_o    = id_mismatch_q;
   assign store_pending_o  = store_pending_q;
   assign load_complete_o  = cpl_pulse_q[0];
   assign store_complete_o = cpl_pulse_q[1];

   // Merge when every cluster has a head entry and the output slot frees up; load the output register
   always_comb begin
      merge      = ~|fifo_empty && (!resp_valid_q || resp_ready_i);
      mismatch   = 1'b0;
      exc_any    = 1'b0;
      unused_res = 1'b0;
      for (int c = 0; c < NrClusters; c++) begin
         mismatch = mismatch | (fifo_rdata[c][ResultWidth +: TransIdWidth] != fifo_rdata[0][ResultWidth +: TransIdWidth]);
         exc_any  = exc_any | fifo_rdata[c][EntryWidth-1];
         if (c > 0) unused_res = unused_res ^ (^fifo_rdata[c][ResultWidth-1:0]);
      end
      resp_valid_d     = merge | (resp_valid_q & ~resp_ready_i);
      resp_result_d    = merge ? fifo_rdata[0][ResultWidth-1:0] : resp_result_q;
      resp_trans_id_d  = merge ? fifo_rdata[0][ResultWidth +: TransIdWidth] : resp_trans_id_q;
      resp_exception_d = merge ? exc_any : resp_exception_q;
      id_mismatch_d    = id_mismatch_q | (merge & mismatch);
      store_pending_d  = |cl_store_pending_i;
   end

   // Completion counters: index 0 tracks loads, 1 stores; all non-zero releases one merged pulse
   always_comb begin
      cpl_all = '1;
      for (int k = 0; k < 2; k++)
         for (int c = 0; c < NrClusters; c++)
            if (cnt_q[k][c] == '0) cpl_all[k] = 1'b0;
      for (int k = 0; k < 2; k++)
         for (int c = 0; c < NrClusters; c++)
            cnt_d[k][c] = (cpl[k][c] && !cpl_all[k]) ? ((cnt_q[k][c] == CntMax) ? cnt_q[k][c] : cnt_q[k][c] + CntOne)
                        : (!cpl[k][c] && cpl_all[k]) ? cnt_q[k][c] - CntOne
                        : cnt_q[k][c];
      cpl_pulse_d = cpl_all;
   end

   // Output register, sticky error, status and counter state
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         resp_valid_q     <= 1'b0;
         resp_result_q    <= '0;
         resp_trans_id_q  <= '0;
         resp_exception_q <= 1'b0;
         id_mismatch_q    <= 1'b0;
         store_pending_q  <= 1'b0;
         cnt_q            <= '0;
         cpl_pulse_q      <= '0;
      end else begin
         resp_valid_q     <= resp_valid_d;
         resp_result_q    <= resp_result_d;
         resp_trans_id_q  <= resp_trans_id_d;
         resp_exception_q <= resp_exception_d;
         id_mismatch_q    <= id_mismatch_d;
         store_pending_q  <= store_pending_d;
         cnt_q            <= cnt_d;
         cpl_pulse_q      <= cpl_pulse_d;
      end
   end

   for (genvar k = 0; k < 2; k++) begin : g_sat_k
      for (genvar c = 0; c < NrClusters; c++) begin : g_sat_c
         a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
            !(cpl[k][c] && !cpl_all[k] && cnt_q[k][c] == CntMax));
      end
   end
endmodule
